score_window_buffer: RTL
========================

Name: score_window_buffer

Overview:
- Parametrised successor of the scoring-path point buffer. It collects per-point samples from CHANNELS parallel data streams into DEPTH-deep sliding shift windows.
- It emits a registered snapshot of all windows with a valid/ready handshake, in either sliding (overlapping) or block (non-overlapping) mode.
- It sits between the calibration-point producer and the score calculator. It adds fill tracking, flush and overflow detection.

Parameters:
- DATA_W, 8, bits per sample
- DEPTH, 5, window length in points (>=2)
- CHANNELS, 2, number of parallel input streams (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cal_point_rdy  in  1  input point valid; one point accepted per cycle while high
- data_in_all  in  CHANNELS*DATA_W  channel c sample at bits [c*DATA_W +: DATA_W]
- mode  in  1  0 = SLIDE, 1 = BLOCK; latched as described below
- flush  in  1  synchronous clear of fill state and output
- win_ready  in  1  downstream accepts the window
- win_valid  out  1  window snapshot valid
- win_data_all  out  CHANNELS*DEPTH*DATA_W  element k of channel c at [(c*DEPTH+k)*DATA_W +: DATA_W]; k=0 is the newest point
- fill_cnt  out  $clog2(DEPTH+1)  points held toward the current window
- overflow  out  1  sticky: a window was dropped

Behaviour:
- Reset (rst=1 at an edge): all shift registers cleared to 0; win_data_all=0; win_valid=0; fill_cnt=0; overflow=0; latched mode=SLIDE. rst overrides every other input.
- Shift, on each edge with cal_point_rdy=1 and flush=0:
  - sr[c][0] <= din[c]
  - sr[c][k] <= sr[c][k-1] for k=1..DEPTH-1
  - the oldest sample is discarded.
- Mode latch: mode is sampled only on an accepted point while fill_cnt==0. Changes at other times take effect at the next empty window.
- fill_cnt, SLIDE mode: increments per accepted point, saturates at DEPTH.
- fill_cnt, BLOCK mode: increments per accepted point. On the point that makes it DEPTH, it returns to 0 at that same edge.
- Window event = an accepted point whose post-shift fill reaches DEPTH.
  - SLIDE: every accepted point once full (stride 1).
  - BLOCK: every DEPTH-th point (stride DEPTH).
- Output stage, on a window event at edge N:
  - if win_valid==0 or win_ready==1: win_data_all <= post-shift window contents, win_valid=1 visible after edge N. Latency is 1 cycle from point acceptance to win_valid.
  - if win_valid==1 and win_ready==0: the new window is dropped; win_data_all holds; overflow <= 1.
- Handshake:
  - transfer occurs on an edge with win_valid & win_ready.
  - with no new event that edge, win_valid <= 0.
  - simultaneous transfer and event: new snapshot loaded, win_valid stays 1, no overflow.
  - win_data_all is stable while win_valid=1 and win_ready=0.
- flush=1 at an edge:
  - fill_cnt=0, win_valid=0, overflow=0.
  - shift contents unchanged.
  - a coincident cal_point_rdy point is discarded (flush wins).
- Flush or reset mid-window: the partial window is never emitted. The next window needs DEPTH fresh points.
- Samples are passed unmodified; no arithmetic on data.

Decomposition:
- Package score_buf_pkg holds:
  - default constants SCORE_DATA_W=8, SCORE_DEPTH=5, SCORE_CHANNELS=2
  - mode encoding MODE_SLIDE=1'b0, MODE_BLOCK=1'b1
  - a fill-count width function
- Sub-module score_shift_lane: one channel's DEPTH x DATA_W shift register with shift-enable and synchronous clear, exposing its packed contents. It is instantiated CHANNELS times via generate. Fill counter, mode latch and output handshake stay in the top.

Test Plan:
- Points are applied on consecutive cycles with cal_point_rdy=1. ch0 sequence: 12,33,156,26,199,2,51. ch1 sequence: 24,66,224,99,96,137,8.
- SLIDE, defaults, win_ready=1:
  - stimulus: ch0/ch1 sequences above.
  - response: win_valid first high the cycle after the 5th point. ch0 window k0..k4 = 199,26,156,33,12; ch1 = 96,99,224,66,24.
  - next two cycles: ch0 = 2,199,26,156,33, then 51,2,199,26,156.
  - fill_cnt sequence 1,2,3,4,5,5,5.
- BLOCK mode:
  - stimulus: same points, then 3 more (ch0: 7,8,9 / ch1: 1,2,3).
  - response: first window after point 5, as in the SLIDE case. Second window after point 10, ch0 = 9,8,7,51,2. fill_cnt returns to 0 after points 5 and 10.
- Backpressure:
  - stimulus: SLIDE, win_ready=0 from point 5 onward.
  - response: win_data_all holds the 199… window; overflow=1 after point 6. Asserting win_ready drops win_valid next cycle. overflow stays 1 until flush.
- Flush mid-window:
  - stimulus: 3 points, then flush together with a 4th point.
  - response: fill_cnt=0, the 4th point is ignored, no window until 5 new points.
- Reset priority:
  - stimulus: rst=1 while win_valid=1 and cal_point_rdy=1.
  - response: all outputs 0 next cycle; a mode=1 change made mid-window is ignored until fill_cnt==0.

Source files
------------

// File: rtl/score_buf_pkg.sv
// Shared constants, mode encoding and sizing helper for the scoring-path window buffer.
package score_buf_pkg;

  localparam int SCORE_DATA_W   = 8;
  localparam int SCORE_DEPTH    = 5;
  localparam int SCORE_CHANNELS = 2;

  typedef enum logic {
    MODE_SLIDE = 1'b0,
    MODE_BLOCK = 1'b1
  } mode_e;

  // Width needed to count 0..depth points inclusive.
  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/score_shift_lane.sv
// One channel's DEPTH-deep sample shift register; element 0 holds the newest point.
module score_shift_lane #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 5
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    shift_en,
  input  logic [DATA_W-1:0]       din,
  output logic [DEPTH*DATA_W-1:0] contents
);

  logic [DEPTH*DATA_W-1:0] sr;
  logic [DEPTH*DATA_W-1:0] sr_shifted;

  assign sr_shifted = {sr[(DEPTH-1)*DATA_W-1:0], din};

  // contents shows the lane as it will stand after this edge, so the top can
  // snapshot a window in the same cycle its final point arrives.
  assign contents = shift_en ? sr_shifted : sr;

  // NOTE: this storage is cleared on reset because it is observable through the window snapshot.
  always_ff @(posedge clk) begin
    if (clear) begin
      sr <= '0;
    end else if (shift_en) begin
      // NOTE: non-blocking assignments make every flop load from pre-edge values.
      sr <= sr_shifted;
    end
  end

endmodule

// File: rtl/score_window_buffer.sv
// Collects CHANNELS parallel sample streams into DEPTH-point windows and hands
// registered snapshots downstream with valid/ready, in sliding or block mode.
module score_window_buffer
  import score_buf_pkg::*;
#(
  parameter int DATA_W   = SCORE_DATA_W,
  parameter int DEPTH    = SCORE_DEPTH,
  parameter int CHANNELS = SCORE_CHANNELS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cal_point_rdy,
  input  logic [CHANNELS*DATA_W-1:0]          data_in_all,
  input  logic                                mode,
  input  logic                                flush,
  input  logic                                win_ready,
  output logic                                win_valid,
  output logic [CHANNELS*DEPTH*DATA_W-1:0]    win_data_all,
  output logic [fill_w(DEPTH)-1:0]            fill_cnt,
  output logic                                overflow
);

  localparam int FW     = fill_w(DEPTH);
  localparam int LANE_W = DEPTH * DATA_W;
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  localparam logic [FW-1:0] LAST = FW'(DEPTH - 1);

  logic                         accept;
  logic                         win_evt;
  mode_e                        mode_q;
  mode_e                        eff_mode;
  logic [FW-1:0]                fill_d;
  logic [CHANNELS*LANE_W-1:0]   window_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    score_shift_lane #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_lane (
      .clk      (clk),
      .clear    (rst),
      .shift_en (accept),
      .din      (data_in_all[c*DATA_W +: DATA_W]),
      .contents (window_d[c*LANE_W +: LANE_W])
    );
  end

  // A window's mode is fixed by its first point; later mode changes wait for an empty window.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    accept   = cal_point_rdy && !flush;
    eff_mode = (fill_cnt == '0) ? mode_e'(mode) : mode_q;
    win_evt  = accept && (fill_cnt >= LAST);
    fill_d   = fill_cnt;
    if (accept) begin
      if (win_evt) fill_d = (eff_mode == MODE_BLOCK) ? '0 : FULL;
      else         fill_d = fill_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt     <= '0;
      mode_q       <= MODE_SLIDE;
      win_valid    <= 1'b0;
      win_data_all <= '0;
      overflow     <= 1'b0;
    end else if (flush) begin
      fill_cnt  <= '0;
      win_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      fill_cnt <= fill_d;
      if (accept && fill_cnt == '0) mode_q <= mode_e'(mode);
      if (win_evt) begin
        // A pending, unaccepted snapshot is never overwritten; the new window is lost instead.
        if (!win_valid || win_ready) begin
          win_data_all <= window_d;
          win_valid    <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule
